// File: rtl/ysyx_22040895_ifu_fsm.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22040895_ifu_fsm
// Purpose  : Instruction fetch unit. Owns the fetch PC and issues one request
//            at a time to instruction memory (valid/ready request channel,
//            valid-only response channel). Presents one fetched instruction
//            at a time to decode over a valid/ready handshake. Handles
//            redirects from execute and squashes wrong-path fetches.
// Ports    : clk, rst (sync, active-high)
//            redirect_valid_i / redirect_pc_i        - redirect from execute
//            imem_req_valid_o / imem_req_addr_o /
//            imem_req_ready_i                        - fetch request channel
//            imem_resp_valid_i / imem_resp_inst_i /
//            imem_resp_err_i                         - fetch response channel
//            inst_o_ifu / pc_o_ifu / valid_o_ifu /
//            ready_i_ifu / fetch_err_o_ifu           - decode interface
//            perf_fetch_cnt_o / perf_stall_cnt_o     - only with the macro
// Options  : YSYX_22040895_IFU_PERF_EN adds the two performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22040895_ifu_fsm #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid_i,
    input  logic [63:0] redirect_pc_i,
    output logic        imem_req_valid_o,
    output logic [63:0] imem_req_addr_o,
    input  logic        imem_req_ready_i,
    input  logic        imem_resp_valid_i,
    input  logic [31:0] imem_resp_inst_i,
    input  logic        imem_resp_err_i,
    output logic [31:0] inst_o_ifu,
    output logic [63:0] pc_o_ifu,
    output logic        valid_o_ifu,
    input  logic        ready_i_ifu,
    output logic        fetch_err_o_ifu
`ifdef YSYX_22040895_IFU_PERF_EN
    ,
    output logic [63:0] perf_fetch_cnt_o,
    output logic [63:0] perf_stall_cnt_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_nxt;
    logic [63:0] pc_r;
    logic [63:0] pc_nxt;
    logic        kill_r;
    logic        kill_nxt;
    logic        capture_en;
    logic [31:0] inst_r;
    logic [63:0] pcout_r;
    logic        err_r;
    logic [63:0] redirect_tgt;

    // Redirect targets are word aligned; the low two bits are dropped.
    assign redirect_tgt = redirect_pc_i & ~64'h3;

    // ------------------------------------------------------------------
    // Next-state / next-PC logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt  = state_r;
        pc_nxt     = pc_r;
        kill_nxt   = kill_r;
        capture_en = 1'b0;

        case (state_r)
            S_IDLE: begin
                state_nxt = S_REQ;
                if (redirect_valid_i) begin
                    pc_nxt = redirect_tgt;
                end
            end

            S_REQ: begin
                if (redirect_valid_i) begin
                    pc_nxt = redirect_tgt;
                end
                if (imem_req_ready_i) begin
                    state_nxt = S_WAIT;
                    // The old address was accepted this cycle; its
                    // response belongs to the wrong path.
                    if (redirect_valid_i) begin
                        kill_nxt = 1'b1;
                    end
                end
            end

            S_WAIT: begin
                if (redirect_valid_i) begin
                    pc_nxt   = redirect_tgt;
                    kill_nxt = 1'b1;
                end
                if (imem_resp_valid_i) begin
                    if (kill_r || redirect_valid_i) begin
                        kill_nxt  = 1'b0;
                        state_nxt = S_REQ;
                    end else begin
                        capture_en = 1'b1;
                        state_nxt  = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                // A redirect wins over a coincident decode handshake.
                if (redirect_valid_i) begin
                    pc_nxt    = redirect_tgt;
                    state_nxt = S_REQ;
                end else if (ready_i_ifu) begin
                    pc_nxt    = pc_r + 64'd4;
                    state_nxt = S_REQ;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            pc_r    <= RESET_PC;
            kill_r  <= 1'b0;
        end else begin
            state_r <= state_nxt;
            pc_r    <= pc_nxt;
            kill_r  <= kill_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Presented-instruction registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_r  <= 32'd0;
            pcout_r <= 64'd0;
            err_r   <= 1'b0;
        end else if (capture_en) begin
            inst_r  <= imem_resp_err_i ? NOP_INST : imem_resp_inst_i;
            pcout_r <= pc_r;
            err_r   <= imem_resp_err_i;
        end
    end

    assign imem_req_valid_o = (state_r == S_REQ);
    assign imem_req_addr_o  = pc_r;
    assign valid_o_ifu      = (state_r == S_HOLD);
    assign inst_o_ifu       = inst_r;
    assign pc_o_ifu         = pcout_r;
    assign fetch_err_o_ifu  = err_r;

`ifdef YSYX_22040895_IFU_PERF_EN
    // ------------------------------------------------------------------
    // Performance counters (free-running, wrap at 2^64)
    // ------------------------------------------------------------------
    logic [63:0] perf_fetch_r;
    logic [63:0] perf_stall_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_r <= 64'd0;
            perf_stall_r <= 64'd0;
        end else begin
            if ((state_r == S_HOLD) && ready_i_ifu && !redirect_valid_i) begin
                perf_fetch_r <= perf_fetch_r + 64'd1;
            end
            if ((state_r == S_REQ) || (state_r == S_WAIT)) begin
                perf_stall_r <= perf_stall_r + 64'd1;
            end
        end
    end

    assign perf_fetch_cnt_o = perf_fetch_r;
    assign perf_stall_cnt_o = perf_stall_r;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22040895_ifu_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_22040895_ifu_fsm
// Purpose  : Self-checking bench for the fetch unit. A behavioural memory
//            answers requests; directed scenarios plus a randomized run are
//            checked against the program-order PC stream expected at decode.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_22040895_ifu_fsm;

    localparam logic [63:0] RESET_PC = 64'h8000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid_i = 1'b0;
    logic [63:0] redirect_pc_i = 64'd0;
    logic        imem_req_valid_o;
    logic [63:0] imem_req_addr_o;
    logic        imem_req_ready_i = 1'b1;
    logic        imem_resp_valid_i = 1'b0;
    logic [31:0] imem_resp_inst_i = 32'd0;
    logic        imem_resp_err_i = 1'b0;
    logic [31:0] inst_o_ifu;
    logic [63:0] pc_o_ifu;
    logic        valid_o_ifu;
    logic        ready_i_ifu = 1'b1;
    logic        fetch_err_o_ifu;
`ifdef YSYX_22040895_IFU_PERF_EN
    logic [63:0] perf_fetch_cnt;
    logic [63:0] perf_stall_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Memory model knobs
    int   mem_lat     = 1;
    bit   mem_rnd     = 1'b0;
    bit   inject_resp = 1'b0;
    bit   m_pend      = 1'b0;
    int   m_cnt       = 0;
    logic [63:0] m_addr = 64'd0;

    always #5 clk = ~clk;

    ysyx_22040895_ifu_fsm #(
        .RESET_PC(RESET_PC),
        .NOP_INST(NOP_INST)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_resp_valid_i(imem_resp_valid_i),
        .imem_resp_inst_i (imem_resp_inst_i),
        .imem_resp_err_i  (imem_resp_err_i),
        .inst_o_ifu       (inst_o_ifu),
        .pc_o_ifu         (pc_o_ifu),
        .valid_o_ifu      (valid_o_ifu),
        .ready_i_ifu      (ready_i_ifu),
        .fetch_err_o_ifu  (fetch_err_o_ifu)
`ifdef YSYX_22040895_IFU_PERF_EN
        ,
        .perf_fetch_cnt_o (perf_fetch_cnt),
        .perf_stall_cnt_o (perf_stall_cnt)
`endif
    );

    // Memory contents: a word derived from its address; one error region.
    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return a[31:0] ^ 32'hDEAD_0000;
    endfunction

    function automatic logic err_of(input logic [63:0] a);
        return (a[7:2] == 6'h08);
    endfunction

    // Behavioural instruction memory: acts 1 ns after each falling edge so
    // knobs written by the test tasks at the falling edge are already seen.
    always @(negedge clk) begin
        #1;
        imem_resp_valid_i = inject_resp;
        imem_resp_inst_i  = $urandom;
        imem_resp_err_i   = 1'($urandom_range(0, 1));
        if (rst) begin
            m_pend           = 1'b0;
            imem_req_ready_i = 1'b1;
        end else begin
            if (m_pend) begin
                if (m_cnt <= 1) begin
                    imem_resp_valid_i = 1'b1;
                    imem_resp_inst_i  = inst_of(m_addr);
                    imem_resp_err_i   = err_of(m_addr);
                    m_pend            = 1'b0;
                end else begin
                    m_cnt = m_cnt - 1;
                end
            end
            imem_req_ready_i = mem_rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (imem_req_valid_o && imem_req_ready_i) begin
                m_pend = 1'b1;
                m_addr = imem_req_addr_o;
                m_cnt  = mem_rnd ? int'($urandom_range(1, 4)) : mem_lat;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (imem_req_valid_o !== 1'b0) begin n_errors++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid_o); end
        n_checks++; if (valid_o_ifu !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", valid_o_ifu); end
        n_checks++; if (imem_req_addr_o !== RESET_PC) begin n_errors++; $display("FAIL reset_addr: got %h expected %h", imem_req_addr_o, RESET_PC); end
        n_checks++; if (inst_o_ifu !== 32'd0) begin n_errors++; $display("FAIL reset_inst: got %h expected 0", inst_o_ifu); end
        n_checks++; if (pc_o_ifu !== 64'd0) begin n_errors++; $display("FAIL reset_pc: got %h expected 0", pc_o_ifu); end
        n_checks++; if (fetch_err_o_ifu !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b expected 0", fetch_err_o_ifu); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (imem_req_valid_o !== 1'b1) begin n_errors++; $display("FAIL first_req_valid: got %b expected 1", imem_req_valid_o); end
        n_checks++; if (imem_req_addr_o !== RESET_PC) begin n_errors++; $display("FAIL first_req_addr: got %h expected %h", imem_req_addr_o, RESET_PC); end
    endtask

    // Memory always ready, 1-cycle response, decode always ready.
    task automatic test_stream();
        logic [63:0] p;
        for (int i = 0; i < 9; i++) begin
            p = RESET_PC + 64'(4 * (i / 3));
            n_checks++; if (imem_req_valid_o !== (i % 3 == 0)) begin n_errors++; $display("FAIL stream_req_valid[%0d]: got %b expected %b", i, imem_req_valid_o, (i % 3 == 0)); end
            if (i % 3 == 0) begin
                n_checks++; if (imem_req_addr_o !== p) begin n_errors++; $display("FAIL stream_req_addr[%0d]: got %h expected %h", i, imem_req_addr_o, p); end
            end
            n_checks++; if (valid_o_ifu !== (i % 3 == 2)) begin n_errors++; $display("FAIL stream_valid[%0d]: got %b expected %b", i, valid_o_ifu, (i % 3 == 2)); end
            if (i % 3 == 2) begin
                n_checks++; if (pc_o_ifu !== p) begin n_errors++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, pc_o_ifu, p); end
                n_checks++; if (inst_o_ifu !== inst_of(p)) begin n_errors++; $display("FAIL stream_inst[%0d]: got %h expected %h", i, inst_o_ifu, inst_of(p)); end
            end
            @(negedge clk);
        end
    endtask

    // Decode back-pressure for 5 cycles while an instruction is held.
    task automatic test_stall();
        logic [63:0] p;
        p = RESET_PC + 64'hC;
        ready_i_ifu = 1'b0;
        for (int n = 0; n < 20 && !valid_o_ifu; n++) @(negedge clk);
        n_checks++; if (valid_o_ifu !== 1'b1) begin n_errors++; $display("FAIL stall_wait_valid: got %b expected 1", valid_o_ifu); end
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (valid_o_ifu !== 1'b1) begin n_errors++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, valid_o_ifu); end
            n_checks++; if (pc_o_ifu !== p) begin n_errors++; $display("FAIL stall_pc[%0d]: got %h expected %h", i, pc_o_ifu, p); end
            n_checks++; if (inst_o_ifu !== inst_of(p)) begin n_errors++; $display("FAIL stall_inst[%0d]: got %h expected %h", i, inst_o_ifu, inst_of(p)); end
            n_checks++; if (imem_req_valid_o !== 1'b0) begin n_errors++; $display("FAIL stall_no_req[%0d]: got %b expected 0", i, imem_req_valid_o); end
            @(negedge clk);
        end
        ready_i_ifu = 1'b1;
        @(negedge clk);
        n_checks++; if (imem_req_valid_o !== 1'b1) begin n_errors++; $display("FAIL stall_next_req: got %b expected 1", imem_req_valid_o); end
        n_checks++; if (imem_req_addr_o !== p + 64'd4) begin n_errors++; $display("FAIL stall_next_addr: got %h expected %h", imem_req_addr_o, p + 64'd4); end
    endtask

    // Redirect coincident with decode ready in the hold state.
    task automatic test_redirect_hold();
        for (int n = 0; n < 20 && !valid_o_ifu; n++) @(negedge clk);
        n_checks++; if (pc_o_ifu !== 64'h8000_0010) begin n_errors++; $display("FAIL rdh_pc: got %h expected 80000010", pc_o_ifu); end
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 64'h8000_2000;
        ready_i_ifu      = 1'b1;
        @(negedge clk);
        redirect_valid_i = 1'b0;
        n_checks++; if (valid_o_ifu !== 1'b0) begin n_errors++; $display("FAIL rdh_valid: got %b expected 0", valid_o_ifu); end
        n_checks++; if (imem_req_valid_o !== 1'b1) begin n_errors++; $display("FAIL rdh_req_valid: got %b expected 1", imem_req_valid_o); end
        n_checks++; if (imem_req_addr_o !== 64'h8000_2000) begin n_errors++; $display("FAIL rdh_req_addr: got %h expected 80002000", imem_req_addr_o); end
    endtask

    // Redirect while waiting; response arrives two cycles later.
    task automatic test_redirect_wait();
        mem_lat = 3;
        @(negedge clk);
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 64'h8000_1002;
        @(negedge clk);
        redirect_valid_i = 1'b0;
        mem_lat = 1;
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (valid_o_ifu !== 1'b0) begin n_errors++; $display("FAIL rdw_valid[%0d]: got %b expected 0", i, valid_o_ifu); end
            n_checks++; if (imem_req_valid_o !== 1'b0) begin n_errors++; $display("FAIL rdw_req[%0d]: got %b expected 0", i, imem_req_valid_o); end
            @(negedge clk);
        end
        n_checks++; if (valid_o_ifu !== 1'b0) begin n_errors++; $display("FAIL rdw_discard_valid: got %b expected 0", valid_o_ifu); end
        n_checks++; if (imem_req_valid_o !== 1'b1) begin n_errors++; $display("FAIL rdw_req_valid: got %b expected 1", imem_req_valid_o); end
        n_checks++; if (imem_req_addr_o !== 64'h8000_1000) begin n_errors++; $display("FAIL rdw_req_addr: got %h expected 80001000", imem_req_addr_o); end
    endtask

    // Faulting fetch at 0x80000020, then normal fetch at 0x80000024.
    task automatic test_error();
        for (int n = 0; n < 20 && !valid_o_ifu; n++) @(negedge clk);
        n_checks++; if (pc_o_ifu !== 64'h8000_1000) begin n_errors++; $display("FAIL err_pre_pc: got %h expected 80001000", pc_o_ifu); end
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 64'h8000_0020;
        @(negedge clk);
        redirect_valid_i = 1'b0;
        for (int n = 0; n < 20 && !valid_o_ifu; n++) @(negedge clk);
        n_checks++; if (valid_o_ifu !== 1'b1) begin n_errors++; $display("FAIL err_valid: got %b expected 1", valid_o_ifu); end
        n_checks++; if (inst_o_ifu !== NOP_INST) begin n_errors++; $display("FAIL err_inst: got %h expected %h", inst_o_ifu, NOP_INST); end
        n_checks++; if (fetch_err_o_ifu !== 1'b1) begin n_errors++; $display("FAIL err_flag: got %b expected 1", fetch_err_o_ifu); end
        n_checks++; if (pc_o_ifu !== 64'h8000_0020) begin n_errors++; $display("FAIL err_pc: got %h expected 80000020", pc_o_ifu); end
        @(negedge clk);
        for (int n = 0; n < 20 && !valid_o_ifu; n++) @(negedge clk);
        n_checks++; if (pc_o_ifu !== 64'h8000_0024) begin n_errors++; $display("FAIL err_next_pc: got %h expected 80000024", pc_o_ifu); end
        n_checks++; if (fetch_err_o_ifu !== 1'b0) begin n_errors++; $display("FAIL err_next_flag: got %b expected 0", fetch_err_o_ifu); end
        n_checks++; if (inst_o_ifu !== inst_of(64'h8000_0024)) begin n_errors++; $display("FAIL err_next_inst: got %h expected %h", inst_o_ifu, inst_of(64'h8000_0024)); end
    endtask

    // Reset while waiting, stray response in the following cycle.
    task automatic test_reset_mid();
        for (int n = 0; n < 20 && !imem_req_valid_o; n++) @(negedge clk);
        n_checks++; if (imem_req_valid_o !== 1'b1) begin n_errors++; $display("FAIL rstm_req: got %b expected 1", imem_req_valid_o); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        inject_resp = 1'b1;
        n_checks++; if (valid_o_ifu !== 1'b0) begin n_errors++; $display("FAIL rstm_valid: got %b expected 0", valid_o_ifu); end
        n_checks++; if (imem_req_valid_o !== 1'b0) begin n_errors++; $display("FAIL rstm_req_valid: got %b expected 0", imem_req_valid_o); end
        n_checks++; if (imem_req_addr_o !== RESET_PC) begin n_errors++; $display("FAIL rstm_addr: got %h expected %h", imem_req_addr_o, RESET_PC); end
        n_checks++; if (inst_o_ifu !== 32'd0) begin n_errors++; $display("FAIL rstm_inst: got %h expected 0", inst_o_ifu); end
        n_checks++; if (pc_o_ifu !== 64'd0) begin n_errors++; $display("FAIL rstm_pc: got %h expected 0", pc_o_ifu); end
        n_checks++; if (fetch_err_o_ifu !== 1'b0) begin n_errors++; $display("FAIL rstm_err: got %b expected 0", fetch_err_o_ifu); end
`ifdef YSYX_22040895_IFU_PERF_EN
        n_checks++; if (perf_fetch_cnt !== 64'd0) begin n_errors++; $display("FAIL rstm_perf_fetch: got %0d expected 0", perf_fetch_cnt); end
        n_checks++; if (perf_stall_cnt !== 64'd0) begin n_errors++; $display("FAIL rstm_perf_stall: got %0d expected 0", perf_stall_cnt); end
`endif
        rst = 1'b0;
        @(negedge clk);
        inject_resp = 1'b0;
        n_checks++; if (imem_req_valid_o !== 1'b1) begin n_errors++; $display("FAIL rstm_first_req: got %b expected 1", imem_req_valid_o); end
        n_checks++; if (imem_req_addr_o !== RESET_PC) begin n_errors++; $display("FAIL rstm_first_addr: got %h expected %h", imem_req_addr_o, RESET_PC); end
        n_checks++; if (valid_o_ifu !== 1'b0) begin n_errors++; $display("FAIL rstm_ignored_resp: got %b expected 0", valid_o_ifu); end
    endtask

    // Random memory timing, decode back-pressure and redirects. The model
    // only tracks the program-order PC that decode must see next.
    task automatic test_random();
        logic [63:0] exp_pc;
        logic [31:0] exp_inst;
        int          n_xfer;
        int          n_stall;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst     = 1'b0;
        mem_rnd = 1'b1;
        exp_pc  = RESET_PC;
        n_xfer  = 0;
        n_stall = 0;
        for (int i = 0; i < 800; i++) begin
            ready_i_ifu      = ($urandom_range(0, 9) < 7);
            redirect_valid_i = ($urandom_range(0, 99) < 8);
            redirect_pc_i    = RESET_PC + 64'($urandom_range(0, 4095));
            n_checks++; if (valid_o_ifu && imem_req_valid_o) begin n_errors++; $display("FAIL rnd_req_while_hold[%0d]: got req_valid 1 expected 0", i); end
            if (i > 0 && !valid_o_ifu) n_stall++;
            if (valid_o_ifu && ready_i_ifu && !redirect_valid_i) begin
                exp_inst = err_of(exp_pc) ? NOP_INST : inst_of(exp_pc);
                n_checks++; if (pc_o_ifu !== exp_pc) begin n_errors++; $display("FAIL rnd_pc[%0d]: got %h expected %h", i, pc_o_ifu, exp_pc); end
                n_checks++; if (inst_o_ifu !== exp_inst) begin n_errors++; $display("FAIL rnd_inst[%0d]: got %h expected %h", i, inst_o_ifu, exp_inst); end
                n_checks++; if (fetch_err_o_ifu !== err_of(exp_pc)) begin n_errors++; $display("FAIL rnd_err[%0d]: got %b expected %b", i, fetch_err_o_ifu, err_of(exp_pc)); end
                exp_pc = exp_pc + 64'd4;
                n_xfer++;
            end
            if (redirect_valid_i) exp_pc = redirect_pc_i & ~64'h3;
            @(negedge clk);
        end
        redirect_valid_i = 1'b0;
        n_checks++; if (n_xfer < 20) begin n_errors++; $display("FAIL rnd_progress: got %0d transfers expected at least 20", n_xfer); end
`ifdef YSYX_22040895_IFU_PERF_EN
        n_checks++; if (perf_fetch_cnt !== 64'(n_xfer)) begin n_errors++; $display("FAIL rnd_perf_fetch: got %0d expected %0d", perf_fetch_cnt, n_xfer); end
        n_checks++; if (perf_stall_cnt !== 64'(n_stall)) begin n_errors++; $display("FAIL rnd_perf_stall: got %0d expected %0d", perf_stall_cnt, n_stall); end
`endif
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_hold();
        test_redirect_wait();
        test_error();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ysyx_22040895_ifu_fsm.md
Name: ysyx_22040895_ifu_fsm

Overview:
- Instruction fetch unit: the producer end of the instruction/PC interface that feeds the decode stage.
- Holds the architectural fetch PC and issues requests to instruction memory over a valid/ready request channel plus a valid-only response channel.
- Presents one fetched instruction at a time to decode with a valid/ready handshake.
- Handles redirects from the execute stage (branch, jal, ecall/mret target) and squashes wrong-path fetches.

Parameters:
- RESET_PC, 64'h8000_0000, first fetch address after reset.
- NOP_INST, 32'h0000_0013, instruction word presented when a fetch returns an error.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- redirect_valid_i  in  1  redirect the fetch stream this cycle.
- redirect_pc_i  in  64  redirect target; bits [1:0] ignored (treated as 0).
- imem_req_valid_o  out  1  fetch request valid.
- imem_req_addr_o  out  64  fetch address; always equals the internal pc_r.
- imem_req_ready_i  in  1  memory accepts the request.
- imem_resp_valid_i  in  1  response valid (one cycle, one response per accepted request).
- imem_resp_inst_i  in  32  fetched instruction word.
- imem_resp_err_i  in  1  access fault on this response.
- inst_o_ifu  out  32  instruction to decode.
- pc_o_ifu  out  64  PC of inst_o_ifu.
- valid_o_ifu  out  1  inst_o_ifu/pc_o_ifu valid.
- ready_i_ifu  in  1  decode accepts the instruction.
- fetch_err_o_ifu  out  1  presented instruction came from a faulting fetch.

Behaviour:
- All outputs are registered or decoded from state only; there is no combinational input-to-output path.
- States: S_IDLE, S_REQ, S_WAIT, S_HOLD. Internal registers: pc_r (64), kill_r (1), inst_r, pcout_r, err_r.
- Reset (any state, mid-transaction included):
  - state <= S_IDLE; pc_r <= RESET_PC; kill_r <= 0.
  - inst_o_ifu = 0, pc_o_ifu = 0, valid_o_ifu = 0, fetch_err_o_ifu = 0, imem_req_valid_o = 0.
  - imem_req_addr_o = RESET_PC.
  - Memory is reset in the same cycle; responses arriving in S_IDLE or S_REQ are ignored.
- S_IDLE:
  - Moves to S_REQ unconditionally, so the first request is asserted in the cycle after rst deasserts.
  - A redirect in this state loads pc_r.
- S_REQ: imem_req_valid_o = 1.
  - req_ready && !redirect: go to S_WAIT.
  - req_ready && redirect: the request is accepted with the old address; pc_r <= redirect target; kill_r <= 1; go to S_WAIT.
  - !req_ready && redirect: pc_r <= redirect target; stay in S_REQ, so the new address is presented next cycle.
- S_WAIT: imem_req_valid_o = 0.
  - A redirect sets kill_r <= 1 and loads pc_r.
  - Response arrives with (kill_r || redirect): discard it, clear kill_r, go to S_REQ.
  - Response arrives otherwise:
    - inst_r <= (err ? NOP_INST : resp_inst);
    - err_r <= err; pcout_r <= pc_r;
    - go to S_HOLD.
- S_HOLD: valid_o_ifu = 1; outputs are stable until consumed.
  - ready_i_ifu && !redirect: pc_r <= pc_r + 4 (modulo 2^64 wrap); go to S_REQ.
  - Redirect (regardless of ready_i_ifu): the held instruction is squashed; pc_r <= redirect target; go to S_REQ.
  - A decode handshake coincident with a redirect does not count as a transfer; downstream qualifies it with redirect.
- Output gating:
  - valid_o_ifu = 0 outside S_HOLD.
  - inst_o_ifu, pc_o_ifu and fetch_err_o_ifu hold their last values but are meaningless when valid is low.
- Latency:
  - With memory ready and a 1-cycle response, one instruction is delivered every 3 cycles at best (REQ -> WAIT -> HOLD).
  - No request is issued while an instruction is held; at most one request is outstanding.
- An error response does not stop fetch; after the erroring instruction is consumed, the PC advances by 4 as normal.

Optional Feature:
- Macro: YSYX_22040895_IFU_PERF_EN.
- When defined, adds two output ports and their counters. Both reset to 0 and wrap at 2^64.
  - perf_fetch_cnt_o (64): increments on every S_HOLD cycle with ready_i_ifu && !redirect.
  - perf_stall_cnt_o (64): increments on every cycle spent in S_REQ or S_WAIT.
- When undefined, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset release, memory always ready, 1-cycle response, decode always ready -> requests at 0x80000000, 0x80000004, 0x80000008; each valid_o_ifu pulse carries the matching PC and instruction, one per 3 cycles.
- Decode holds ready_i_ifu=0 for 5 cycles in S_HOLD -> inst_o_ifu/pc_o_ifu stable, no new request issued; request for pc+4 appears the cycle after ready_i_ifu=1.
- Redirect to 0x80001002 while in S_WAIT, response arrives 2 cycles later -> response discarded, valid_o_ifu stays 0, next request address 0x80001000.
- Redirect to 0x80002000 in the same cycle as decode ready in S_HOLD at PC 0x80000010 -> no advance to 0x80000014; next request 0x80002000.
- Response with imem_resp_err_i=1 at PC 0x80000020 -> inst_o_ifu=0x00000013, fetch_err_o_ifu=1, pc_o_ifu=0x80000020; next fetch 0x80000024 with fetch_err_o_ifu=0.
- rst asserted while in S_WAIT, with a response in the following cycle -> response ignored, all outputs at reset values, first request at 0x80000000 one cycle after rst drops; with YSYX_22040895_IFU_PERF_EN both counters read 0.
